// File: rtl/kbd_color_sequencer_pkg.sv
// Shared constants and types for the keyboard-driven color sequencer.
package kbd_color_sequencer_pkg;

  localparam int COLOR_W = 3;
  typedef logic [COLOR_W-1:0] color_t;

  // PS/2 set-2 prefix and arrow-key bytes
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;

  // Digit make codes 0..7
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

endpackage

// File: rtl/kbd_color_sequencer_key_lookup.sv
// Combinational digit make-code to color-index lookup.
module key_lookup
  import kbd_color_sequencer_pkg::*;
(
  input  logic [7:0] code,
  output color_t     idx,
  output logic       hit
);

  // Map the eight digit make codes; anything else is a miss
  always_comb begin
    idx = '0;
    hit = 1'b1;
    case (code)
      SC_D0:   idx = 3'd0;
      SC_D1:   idx = 3'd1;
      SC_D2:   idx = 3'd2;
      SC_D3:   idx = 3'd3;
      SC_D4:   idx = 3'd4;
      SC_D5:   idx = 3'd5;
      SC_D6:   idx = 3'd6;
      SC_D7:   idx = 3'd7;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/kbd_color_sequencer.sv
// Decodes PS/2 scan bytes into a color index that is applied on the next
// falling edge of vsync, so the display never changes color mid-frame.
module kbd_color_sequencer
  import kbd_color_sequencer_pkg::*;
#(
  parameter int     TIMEOUT_CYC = 65535,
  parameter color_t RESET_COLOR = 3'd0
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       scanValid,
  input  logic [7:0] scanCode,
  input  logic       vsyncIn,
  output color_t     outColor,
  output logic       colorPending,
  output logic       errStrobe
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             vsync_q;
  color_t           pend_q;
  color_t           lut_idx;
  logic             lut_hit;
  color_t           target;
  color_t           load_val;
  logic             load;
  logic             err_d;
  logic             timeout;
  logic             boundary;

  key_lookup u_lut (
    .code (scanCode),
    .idx  (lut_idx),
    .hit  (lut_hit)
  );

  // Arrow keys step from whatever will be shown next, not what is shown now
  assign target   = colorPending ? pend_q : outColor;
  assign boundary = vsync_q & ~vsyncIn;
  // The current idle cycle is the TIMEOUT_CYC-th one since the last byte
  assign timeout  = (state_q != ST_IDLE) && !scanValid && (cnt_q >= CNT_MAX - 1'b1);

  // Decoder state register
  always_ff @(posedge pixelClk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, pending-load request and error detection
  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    load     = 1'b0;
    load_val = target;
    case (state_q)
      ST_IDLE: if (scanValid) begin
        if (scanCode == SC_BRK)      state_d = ST_BRK;
        else if (scanCode == SC_EXT) state_d = ST_EXT;
        else if (lut_hit) begin
          load     = 1'b1;
          load_val = lut_idx;
        end else err_d = 1'b1;
      end
      ST_EXT: if (scanValid) begin
        state_d = ST_IDLE;
        if (scanCode == SC_BRK) state_d = ST_EXT_BRK;
        else if (scanCode == SC_UP) begin
          load     = 1'b1;
          load_val = target + color_t'(1);
        end else if (scanCode == SC_DOWN) begin
          load     = 1'b1;
          load_val = target - color_t'(1);
        end else err_d = 1'b1;
      end
      ST_BRK, ST_EXT_BRK: if (scanValid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abandon a stale prefix; timeout never coincides with a byte
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  // Idle-cycle counter: cleared by any byte, saturates at TIMEOUT_CYC
  always_ff @(posedge pixelClk or negedge reset) begin
    if (!reset)             cnt_q <= '0;
    else if (scanValid)     cnt_q <= '0;
    else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  // Color apply at frame boundary; a same-cycle load becomes the next pending
  always_ff @(posedge pixelClk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b1;
      outColor     <= RESET_COLOR;
      pend_q       <= RESET_COLOR;
      colorPending <= 1'b0;
      errStrobe    <= 1'b0;
    end else begin
      vsync_q   <= vsyncIn;
      errStrobe <= err_d;
      if (boundary && colorPending) begin
        outColor     <= pend_q;
        colorPending <= 1'b0;
      end
      if (load) begin
        pend_q       <= load_val;
        colorPending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/kbd_color_sequencer.md
KBD_COLOR_SEQUENCER -- requirements
Module: kbd_color_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 65535: idle cycles after which a partial prefix sequence is abandoned.
REQ-002 Parameter RESET_COLOR, default 3'd0: color index loaded at reset.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 pixelClk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 scanValid  in  1  one-cycle strobe, scanCode valid.
REQ-007 scanCode  in  8  PS/2 set-2 byte from the keyboard receiver.
REQ-008 vsyncIn  in  1  display vertical sync, active-low, same clock domain.
REQ-009 outColor  out  3  color index driven to the display controller.
REQ-010 colorPending  out  1  high while a new color awaits the next frame boundary.
REQ-011 errStrobe  out  1  one-cycle pulse on an unmapped or malformed code.

Function
REQ-012 Decoder FSM SHALL have states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); bytes are consumed only on cycles with scanValid=1.
REQ-013 IDLE: F0->BRK; E0->EXT; mapped digit make code->load pending, stay IDLE; any other byte->errStrobe, stay IDLE.
REQ-014 Digit map: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7.
REQ-015 BRK: any byte->IDLE, no pending update, no error.
REQ-016 EXT: F0->EXT_BRK; 75 (up)->pending=target+1; 72 (down)->pending=target-1; other byte->errStrobe, IDLE; 75/72 also return to IDLE.
REQ-017 EXT_BRK: any byte->IDLE, no update.
REQ-018 target = pending value if colorPending=1, else outColor; increment/decrement are 3-bit modulo (7+1->0, 0-1->7).
REQ-019 Repeated make codes (typematic) SHALL each be processed; a later make overwrites the pending value.
REQ-020 Frame boundary = cycle where registered vsyncIn is 1 and current vsyncIn is 0 (falling edge).
REQ-021 On a boundary cycle with colorPending=1: outColor takes pending value and colorPending clears, both visible the following cycle.
REQ-022 Boundary with colorPending=0: no change.
REQ-023 Pending load coincident with boundary: the previously pending value is applied; the new value becomes pending for the next boundary (colorPending stays 1).
REQ-024 Pending load with no prior pending, coincident with boundary: value is held for the next boundary, not applied this frame.
REQ-025 Timeout counter clears on every scanValid; in BRK/EXT/EXT_BRK, reaching TIMEOUT_CYC idle cycles returns FSM to IDLE with errStrobe pulse; counter saturates in IDLE.
REQ-026 errStrobe SHALL be registered, exactly one cycle per offending event.

Reset
REQ-027 Reset asserted: FSM=IDLE, outColor=RESET_COLOR, colorPending=0, errStrobe=0, timeout counter=0, vsync history register=1.
REQ-028 Reset mid-sequence SHALL discard any prefix and pending color; first post-reset boundary makes no change.

Structure
REQ-029 Shared package holds: scan-code constants (F0, E0, 75, 72, digit codes), FSM state encoding, color width (3).
REQ-030 Digit lookup SHALL be a combinational sub-module key_lookup (8-bit code in, 3-bit index and hit flag out).

Verification
REQ-031 Reset, then bytes 26 and a vsyncIn 1->0 edge -> colorPending=1 after byte, outColor=3 one cycle after edge, colorPending=0.
REQ-032 outColor=7, bytes E0 75, boundary -> outColor=0; then E0 72 E0 72, boundary -> outColor=6.
REQ-033 Bytes F0 26 then boundary -> no change, no errStrobe; byte 1C -> single errStrobe pulse, FSM IDLE.
REQ-034 Byte 3D presented on the same cycle as a boundary while pending=2 -> outColor=2, colorPending stays 1; next boundary -> outColor=7.
REQ-035 Byte E0 then TIMEOUT_CYC idle cycles -> errStrobe pulse, then 16 -> pending=1 (decoded as IDLE make).
REQ-036 Reset asserted between E0 and 75, and with pending=5 -> outColor=RESET_COLOR, colorPending=0, following 75 -> errStrobe.
